// File: rtl/temporizador_regressivo_pkg.sv
// Shared types and defaults for the countdown timer.
// State encoding plus default prescaler and ceiling values.
package temporizador_regressivo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_PAUSED  = 2'd2,
    ST_EXPIRED = 2'd3
  } state_t;

  localparam int CLK_DIV_DEF = 50000000;
  localparam int MAX_SEG_DEF = 999;

endpackage

// File: rtl/temporizador_regressivo_disp.sv
// Display path: binary to BCD and BCD to 7-segment.
// Segments are active-low, bit order gfedcba.
module bin2bcd (
  input  logic [9:0]  bin,
  output logic [3:0]  d0,
  output logic [3:0]  d1,
  output logic [3:0]  d2
);

  logic [21:0] w_sh;

  always_comb begin
    w_sh = {12'd0, bin};
    for (int i = 0; i < 10; i++) begin
      if (w_sh[13:10] > 4'd4) w_sh[13:10] = w_sh[13:10] + 4'd3;
      if (w_sh[17:14] > 4'd4) w_sh[17:14] = w_sh[17:14] + 4'd3;
      if (w_sh[21:18] > 4'd4) w_sh[21:18] = w_sh[21:18] + 4'd3;
      w_sh = {w_sh[20:0], 1'b0};
    end
  end

  assign d0 = w_sh[13:10];
  assign d1 = w_sh[17:14];
  assign d2 = w_sh[21:18];

endmodule

module cb7s (
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    unique case (bcd)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = 7'b1111111;
    endcase
  end

endmodule

// File: rtl/temporizador_regressivo_tick.sv
// One-second prescaler for the countdown timer.
// Holds its count while disabled; tick is high on the wrap cycle.
module gerador_tick #(
  parameter int CLK_DIV = 50000000
) (
  input  logic clk_50,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] r_cnt;
  logic          w_last;

  assign w_last = (r_cnt == LAST);
  assign tick   = enable && w_last;

  always_ff @(posedge clk_50) begin
    if (reset || clear) begin
      r_cnt <= '0;
    end else if (enable) begin
      r_cnt <= w_last ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/temporizador_regressivo.sv
// Countdown timer 0..MAX_SEG seconds with pause/resume,
// latched expiry, one-cycle done pulse and 3-digit display.
module temporizador_regressivo
  import temporizador_regressivo_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEF,
  parameter int MAX_SEG = MAX_SEG_DEF
) (
  input  logic       clk_50,
  input  logic       reset,
  input  logic       load,
  input  logic [9:0] load_val,
  input  logic       start,
  input  logic       pause,
  output logic [9:0] t_seg,
  output logic       running,
  output logic       expired,
  output logic       done,
  output logic [6:0] s0,
  output logic [6:0] s1,
  output logic [6:0] s2
);

  localparam logic [9:0] MAXV = 10'(MAX_SEG);

  state_t     r_state;
  logic [9:0] r_t;
  logic       r_expired;
  logic       r_done;
  logic       w_tick;
  logic       w_en;
  logic [9:0] w_ld;
  logic [3:0] w_d0, w_d1, w_d2;

  assign w_ld = (load_val > MAXV) ? MAXV : load_val;
  // load and pause both suppress the tick in their cycle
  assign w_en = (r_state == ST_RUN) && !load && !pause;

  gerador_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk_50 (clk_50),
    .reset  (reset),
    .clear  (load),
    .enable (w_en),
    .tick   (w_tick)
  );

  always_ff @(posedge clk_50) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_t       <= '0;
      r_expired <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (load) begin
        r_t       <= w_ld;
        r_state   <= ST_IDLE;
        r_expired <= 1'b0;
      end else begin
        unique case (r_state)
          ST_IDLE: begin
            if (!pause && start && r_t != '0) r_state <= ST_RUN;
          end
          ST_RUN: begin
            if (pause) begin
              r_state <= ST_PAUSED;
            end else if (w_tick) begin
              if (r_t == 10'd1) begin
                r_t       <= '0;
                r_state   <= ST_EXPIRED;
                r_expired <= 1'b1;
                r_done    <= 1'b1;
              end else begin
                r_t <= r_t - 10'd1;
              end
            end
          end
          ST_PAUSED: begin
            if (start && !pause) r_state <= ST_RUN;
          end
          ST_EXPIRED: begin
            r_t <= '0;
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign t_seg   = r_t;
  assign running = (r_state == ST_RUN);
  assign expired = r_expired;
  assign done    = r_done;

  bin2bcd u_bcd (.bin(r_t), .d0(w_d0), .d1(w_d1), .d2(w_d2));
  cb7s u_s0 (.bcd(w_d0), .seg(s0));
  cb7s u_s1 (.bcd(w_d1), .seg(s1));
  cb7s u_s2 (.bcd(w_d2), .seg(s2));

endmodule
